// File: rtl/iter_seq_controller.sv
// iter_seq_controller
// Sequencer for an iterative datapath (shift-add multiplier, restoring
// divider, ...). A start request arms the controller, release of start
// launches one operation: a single ld strobe, N_ITER en cycles carrying
// the iteration index on cnt, then a single done strobe.
module iter_seq_controller #(
    parameter int N_ITER = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             early_term,
    output logic             ready,
    output logic             busy,
    output logic             ld,
    output logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LOAD  = 3'd2,
        S_CALC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ITER - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_calc_last;

    // Final iteration of CALC: either the index reached the end or the
    // datapath asked to stop. This cycle still counts as an iteration.
    assign w_calc_last = (r_state == S_CALC) &&
                         ((r_cnt == LAST_IDX) || early_term);

    // State register; reset aborts any operation without a done strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE and ARMED.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_ARMED;
            S_ARMED: if (!start) w_next = S_LOAD;
            S_LOAD:  w_next = S_CALC;
            S_CALC:  if (w_calc_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Iteration index: cleared on LOAD, advanced through CALC, then held
    // through DONE and IDLE so the final index stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_cnt <= '0;
        end else if ((r_state == S_CALC) && !w_calc_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Moore output decode; ld, en and done are one-hot by construction.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        ld    = 1'b0;
        en    = 1'b0;
        done  = 1'b0;
        unique case (r_state)
            S_IDLE:  ready = 1'b1;
            S_ARMED: busy  = 1'b1;
            S_LOAD:  begin busy = 1'b1; ld   = 1'b1; end
            S_CALC:  begin busy = 1'b1; en   = 1'b1; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ready = 1'b1;
        endcase
    end

    assign cnt = r_cnt;

endmodule

// File: tb/tb_iter_seq_controller.sv
// Testbench for iter_seq_controller: two instances (N_ITER=8 and N_ITER=1).
// Stimulus pushes the expected per-cycle output vector into a queue; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_iter_seq_controller;

    localparam int ST_IDLE  = 0;
    localparam int ST_ARMED = 1;
    localparam int ST_LOAD  = 2;
    localparam int ST_CALC  = 3;
    localparam int ST_DONE  = 4;

    typedef struct {
        string      name;
        logic [8:0] v;   // {ready, busy, ld, en, done, cnt[3:0]}
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N_ITER=8 instance
    logic       rst8 = 1'b1, start8 = 1'b0, et8 = 1'b0;
    logic       ready8, busy8, ld8, en8, done8;
    logic [3:0] cnt8;

    // N_ITER=1 instance
    logic       rst1 = 1'b1, start1 = 1'b0, et1 = 1'b0;
    logic       ready1, busy1, ld1, en1, done1;
    logic [0:0] cnt1;

    iter_seq_controller #(.N_ITER(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .early_term(et8),
        .ready(ready8), .busy(busy8), .ld(ld8), .en(en8), .cnt(cnt8), .done(done8)
    );

    iter_seq_controller #(.N_ITER(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .early_term(et1),
        .ready(ready1), .busy(busy1), .ld(ld1), .en(en1), .cnt(cnt1), .done(done1)
    );

    exp_t q8[$];
    exp_t q1[$];
    int   n_total = 0;
    int   n_pass  = 0;
    string tag = "init";

    // Expected output vector for a given state and counter value.
    function automatic logic [8:0] ev(input int st, input int c);
        logic [3:0] c4;
        c4 = c[3:0];
        return {st == ST_IDLE, st != ST_IDLE, st == ST_LOAD,
                st == ST_CALC, st == ST_DONE, c4};
    endfunction

    task automatic report(input string name, input logic [8:0] got, input logic [8:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t got rdy=%b bsy=%b ld=%b en=%b dn=%b cnt=%0d  required rdy=%b bsy=%b ld=%b en=%b dn=%b cnt=%0d",
                     name, $time, got[8], got[7], got[6], got[5], got[4], got[3:0],
                     want[8], want[7], want[6], want[5], want[4], want[3:0]);
        end
    endtask

    // Monitors: one pop per cycle while expectations are pending.
    always @(negedge clk) begin
        if (q8.size() > 0) begin
            exp_t e;
            e = q8.pop_front();
            report(e.name, {ready8, busy8, ld8, en8, done8, cnt8}, e.v);
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            report(e.name, {ready1, busy1, ld1, en1, done1, 3'b000, cnt1}, e.v);
        end
    end

    // One cycle on the N_ITER=8 instance: expected outputs for this cycle,
    // inputs sampled at the closing edge.
    task automatic c8(input logic r, input logic s, input logic e, input int st, input int c);
        exp_t x;
        x.name = tag;
        x.v    = ev(st, c);
        q8.push_back(x);
        rst8   = r;
        start8 = s;
        et8    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic c1(input logic r, input logic s, input logic e, input int st, input int c);
        exp_t x;
        x.name = tag;
        x.v    = ev(st, c);
        q1.push_back(x);
        rst1   = r;
        start1 = s;
        et1    = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // ---------------- N_ITER = 8 ----------------
        tag = "reset8";
        c8(1, 0, 0, ST_IDLE, 0);
        c8(0, 0, 0, ST_IDLE, 0);

        tag = "pulse_full";
        c8(0, 1, 0, ST_IDLE, 0);
        c8(0, 0, 0, ST_ARMED, 0);
        c8(0, 0, 0, ST_LOAD, 0);
        for (int i = 0; i < 8; i++) c8(0, 0, 0, ST_CALC, i);
        c8(0, 0, 0, ST_DONE, 7);
        c8(0, 0, 0, ST_IDLE, 7);

        tag = "held5";
        c8(0, 1, 0, ST_IDLE, 7);
        for (int i = 0; i < 4; i++) c8(0, 1, 0, ST_ARMED, 7);
        c8(0, 0, 0, ST_ARMED, 7);
        c8(0, 0, 0, ST_LOAD, 7);
        for (int i = 0; i < 8; i++) c8(0, 0, 0, ST_CALC, i);
        c8(0, 0, 0, ST_DONE, 7);
        c8(0, 0, 0, ST_IDLE, 7);
        c8(0, 0, 0, ST_IDLE, 7);

        tag = "early_term3";
        c8(0, 1, 0, ST_IDLE, 7);
        c8(0, 0, 1, ST_ARMED, 7);
        c8(0, 0, 1, ST_LOAD, 7);
        for (int i = 0; i < 3; i++) c8(0, 0, 0, ST_CALC, i);
        c8(0, 0, 1, ST_CALC, 3);
        c8(0, 0, 1, ST_DONE, 3);
        c8(0, 0, 1, ST_IDLE, 3);
        c8(0, 0, 0, ST_IDLE, 3);

        tag = "abort_cnt5";
        c8(0, 1, 0, ST_IDLE, 3);
        c8(0, 0, 0, ST_ARMED, 3);
        c8(0, 0, 0, ST_LOAD, 3);
        for (int i = 0; i < 5; i++) c8(0, 0, 0, ST_CALC, i);
        c8(1, 0, 0, ST_CALC, 5);
        c8(0, 0, 0, ST_IDLE, 0);
        c8(0, 0, 0, ST_IDLE, 0);
        tag = "after_abort";
        c8(0, 1, 0, ST_IDLE, 0);
        c8(0, 0, 0, ST_ARMED, 0);
        c8(0, 0, 0, ST_LOAD, 0);
        for (int i = 0; i < 8; i++) c8(0, 0, 0, ST_CALC, i);
        c8(0, 0, 0, ST_DONE, 7);
        c8(0, 0, 0, ST_IDLE, 7);

        tag = "start_toggle_norestart";
        c8(0, 1, 0, ST_IDLE, 7);
        c8(0, 0, 0, ST_ARMED, 7);
        c8(0, 1, 0, ST_LOAD, 7);
        for (int i = 0; i < 8; i++) c8(0, i[0], 0, ST_CALC, i);
        c8(0, 0, 0, ST_DONE, 7);
        c8(0, 0, 0, ST_IDLE, 7);
        c8(0, 0, 0, ST_IDLE, 7);

        tag = "back_to_back";
        c8(0, 1, 0, ST_IDLE, 7);
        c8(0, 0, 0, ST_ARMED, 7);
        c8(0, 0, 0, ST_LOAD, 7);
        for (int i = 0; i < 7; i++) c8(0, 1, 0, ST_CALC, i);
        c8(0, 1, 1, ST_CALC, 7);
        c8(0, 1, 0, ST_DONE, 7);
        c8(0, 1, 0, ST_IDLE, 7);
        c8(0, 0, 0, ST_ARMED, 7);
        c8(0, 0, 0, ST_LOAD, 7);
        c8(0, 0, 0, ST_CALC, 0);
        c8(0, 0, 1, ST_CALC, 1);
        c8(0, 0, 0, ST_DONE, 1);
        c8(0, 0, 0, ST_IDLE, 1);

        // ---------------- N_ITER = 1 ----------------
        tag = "reset1";
        c1(1, 0, 0, ST_IDLE, 0);
        c1(0, 0, 1, ST_IDLE, 0);
        tag = "n1_run";
        c1(0, 1, 1, ST_IDLE, 0);
        c1(0, 1, 1, ST_ARMED, 0);
        c1(0, 0, 1, ST_ARMED, 0);
        c1(0, 0, 1, ST_LOAD, 0);
        c1(0, 0, 0, ST_CALC, 0);
        c1(0, 0, 0, ST_DONE, 0);
        c1(0, 0, 0, ST_IDLE, 0);
        tag = "n1_et_last";
        c1(0, 1, 0, ST_IDLE, 0);
        c1(0, 0, 0, ST_ARMED, 0);
        c1(0, 0, 0, ST_LOAD, 0);
        c1(0, 0, 1, ST_CALC, 0);
        c1(0, 0, 0, ST_DONE, 0);
        c1(0, 0, 0, ST_IDLE, 0);
        c1(0, 0, 0, ST_IDLE, 0);

        // Drain: every queued expectation must have been consumed.
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (q8.size() == 0 && q1.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain got pending=%0d required pending=0", q8.size() + q1.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
